// File: rtl/uart_tx_engine_pkg.sv
// uart_tx_engine_pkg
//   Shared definitions for the UART transmit engine: default timing and burst
//   parameters, the FSM state encoding, and a counter-width helper.
package uart_tx_engine_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;  // 100 MHz / 115200
    localparam int DEF_DBIT         = 8;
    localparam int DEF_BURST_LEN    = 4;

    // state      | meaning
    // ST_IDLE    | line idle, waiting for the upstream buffer to fill
    // ST_LOAD    | one-cycle read strobe, byte captured on exit
    // ST_START   | start bit (tx=0) for one bit period
    // ST_DATA    | DBIT data bits, LSB first
    // ST_STOP    | stop bit (tx=1) for one bit period
    // ST_RELEASE | one extra read strobe that empties the upstream buffer
    // ST_WAIT_CLR| hold until full drops, then pulse done
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_STOP     = 3'd4,
        ST_RELEASE  = 3'd5,
        ST_WAIT_CLR = 3'd6
    } tx_state_e;

    // Counter width for a range of n values; never returns 0 so a degenerate
    // parameter (e.g. a single-byte burst) still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if
//   Read port between the upstream transmit buffer and the transmit engine.
//   full   : buffer holds a complete burst
//   r_data : byte at the buffer read pointer (combinational from the buffer)
//   rd     : one-cycle read strobe that advances the buffer read pointer
//   master = buffer side, slave = engine side.
interface uart_tx_engine_if #(
    parameter int DBIT = 8
);
    logic            full;
    logic [DBIT-1:0] r_data;
    logic            rd;

    modport master (output full, output r_data, input rd);
    modport slave  (input full, input r_data, output rd);
endinterface

// File: rtl/uart_tx_engine_baud_counter.sv
// baud_counter
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 while en is high and flags
//   tick on the cycle the count wraps. Held at zero by reset or en=0, so each
//   enable window starts on a fresh bit boundary.
//   clk   : system clock
//   reset : synchronous active-high reset
//   en    : count enable
//   tick  : high during the last cycle of each bit period
module baud_counter
    import uart_tx_engine_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int             W    = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0]   LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] baud_cnt;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            baud_cnt <= '0;
        end else if (baud_cnt == LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign tick = en && (baud_cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Drains a full upstream buffer one byte at a time and sends each byte as an
//   8N1 frame, LSB first. After the last byte one extra read strobe returns the
//   buffer to empty; done pulses once the buffer reports not-full.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   buf_if : buffer read port (full, r_data in; rd out)
//   tx     : serial line, idle high, registered
//   busy   : high from burst start until return to idle
//   done   : one-cycle pulse when the burst is fully released
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DBIT         = DEF_DBIT,
    parameter int BURST_LEN    = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_engine_if.slave   buf_if,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int                BIT_W     = cnt_width(DBIT);
    localparam int                BYTE_W    = cnt_width(BURST_LEN);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DBIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BURST_LEN - 1);

    tx_state_e         state;
    logic [DBIT-1:0]   shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic              rd_q;
    logic              baud_en;
    logic              tick;

    assign baud_en   = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign buf_if.rd = rd_q;

    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .en    (baud_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            rd_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            rd_q <= 1'b0;
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (buf_if.full) begin
                        busy  <= 1'b1;
                        rd_q  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // r_data is valid while the strobe is high; capture it here only.
                    shreg <= buf_if.r_data;
                    tx    <= 1'b0;
                    state <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        // Next byte and final release both need a strobe.
                        rd_q <= 1'b1;
                        if (byte_cnt != LAST_BYTE) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= ST_LOAD;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    state <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    tx <= 1'b1;
                    if (!buf_if.full) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
